// File: rtl/dca_matrix_row_streamer_pkg.sv
// Shared DCA package: the row-streamer FSM encoding plus the matrix geometry and
// row-count width helpers.
package dca_matrix_row_streamer_pkg;

  // Row-streamer control states
  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StFull  = 2'd1,
    StStore = 2'd2
  } dca_row_state_e;

  // Square matrix geometry: a size selector of N means N rows by N columns
  function automatic int unsigned matrix_num_row(input int unsigned size_para);
    return size_para;
  endfunction

  function automatic int unsigned matrix_num_col(input int unsigned size_para);
    return size_para;
  endfunction

  // Counter width that can hold every value from 0 up to num_row inclusive
  function automatic int unsigned row_count_width(input int unsigned num_row);
    return (num_row < 1) ? 1 : $clog2(num_row + 1);
  endfunction

endpackage

// File: rtl/dca_matrix_row_streamer.sv
// Streams whole matrix rows into a downstream row-shift matrix register, holds the
// full matrix, then drains it out in arrival order. There is no internal data storage;
// both data paths are purely combinational.
// Optional feature: define DCA_ROW_STREAMER_OVERLAP_EN to refill the matrix while it
// drains (each store beat also shifts in a new row).
module dca_matrix_row_streamer
  import dca_matrix_row_streamer_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE_PARA  = 8,
  parameter int unsigned BW_TENSOR_SCALAR  = 32,
  localparam int unsigned MATRIX_NUM_ROW   = matrix_num_row(MATRIX_SIZE_PARA),
  localparam int unsigned MATRIX_NUM_COL   = matrix_num_col(MATRIX_SIZE_PARA),
  localparam int unsigned BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
  localparam int unsigned BW_ROW_COUNT     = row_count_width(MATRIX_NUM_ROW)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [BW_TENSOR_ROW-1:0] load_data,
  output logic                     store_valid,
  input  logic                     store_ready,
  output logic [BW_TENSOR_ROW-1:0] store_data,
  output logic                     store_last,
  input  logic                     drain_request,
  input  logic                     clear_request,
  output logic                     matrix_full,
  output logic [BW_ROW_COUNT-1:0]  row_count,
  output logic                     move_wenable,
  output logic [BW_TENSOR_ROW-1:0] move_wdata_list,
  output logic                     move_renable,
  input  logic [BW_TENSOR_ROW-1:0] move_rdata_list,
  output logic                     init
);

  localparam logic [BW_ROW_COUNT-1:0] CountFull = BW_ROW_COUNT'(MATRIX_NUM_ROW);
  localparam logic [BW_ROW_COUNT-1:0] CountOne  = BW_ROW_COUNT'(1);

  dca_row_state_e            state_q;
  logic [BW_ROW_COUNT-1:0]   count_q;
  logic                      full_q;
  logic [BW_ROW_COUNT-1:0]   store_left;
  logic                      active;
  logic                      load_beat;
  logic                      store_beat;

`ifdef DCA_ROW_STREAMER_OVERLAP_EN
  // Occupancy stays constant during an overlapped drain, so rows still to leave are
  // tracked separately.
  logic [BW_ROW_COUNT-1:0]   drain_left_q;
  assign store_left = drain_left_q;
`else
  assign store_left = count_q;
`endif

  // Reset and clear both kill any handshake in the cycle they are seen
  assign active = ~rstnn & ~clear_request;

  assign move_wdata_list = load_data;
  assign store_data      = move_rdata_list;
  assign init            = ~rstnn & clear_request;
  assign matrix_full     = full_q;
  assign row_count       = count_q;
  assign store_last      = store_valid & (store_left == CountOne);

  // Handshake and row-move strobe decode for the current state
  always_comb begin
    load_ready   = 1'b0;
    store_valid  = 1'b0;
    load_beat    = 1'b0;
    store_beat   = 1'b0;
    move_wenable = 1'b0;
    move_renable = 1'b0;
    if (active) begin
      unique case (state_q)
        StLoad: begin
          load_ready   = 1'b1;
          load_beat    = load_valid;
          move_wenable = load_valid;
        end
        StStore: begin
          store_valid  = 1'b1;
`ifdef DCA_ROW_STREAMER_OVERLAP_EN
          load_ready   = store_ready;
          store_beat   = store_ready & load_valid;
          move_wenable = store_beat;
`else
          store_beat   = store_ready;
`endif
          move_renable = store_beat;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered occupancy count and full flag
  always_ff @(posedge clk) begin
    if (rstnn || clear_request) begin
      state_q      <= StLoad;
      count_q      <= '0;
      full_q       <= 1'b0;
`ifdef DCA_ROW_STREAMER_OVERLAP_EN
      drain_left_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_beat) begin
            count_q <= count_q + CountOne;
            if (count_q + CountOne == CountFull) begin
              state_q <= StFull;
              full_q  <= 1'b1;
            end
          end
        end
        StFull: begin
          if (drain_request) begin
            state_q      <= StStore;
            full_q       <= 1'b0;
`ifdef DCA_ROW_STREAMER_OVERLAP_EN
            drain_left_q <= CountFull;
`endif
          end
        end
        StStore: begin
          if (store_beat) begin
`ifdef DCA_ROW_STREAMER_OVERLAP_EN
            drain_left_q <= drain_left_q - CountOne;
            if (store_last) begin
              state_q <= StFull;
              full_q  <= 1'b1;
            end
`else
            if (store_last) begin
              state_q <= StLoad;
              count_q <= '0;
            end else begin
              count_q <= count_q - CountOne;
            end
`endif
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_row_streamer.sv
// Bench for dca_matrix_row_streamer on a 4x4 matrix of 8-bit scalars. A small row-shift
// register model sits on the move port; loaded rows go into a scoreboard queue and are
// compared when they leave on the store port.
module tb_dca_matrix_row_streamer;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 32;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          rstnn;
  logic          load_valid;
  logic          load_ready;
  logic [RW-1:0] load_data;
  logic          store_valid;
  logic          store_ready;
  logic [RW-1:0] store_data;
  logic          store_last;
  logic          drain_request;
  logic          clear_request;
  logic          matrix_full;
  logic [CW-1:0] row_count;
  logic          move_wenable;
  logic [RW-1:0] move_wdata_list;
  logic          move_renable;
  logic [RW-1:0] move_rdata_list;
  logic          init;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  dca_matrix_row_streamer #(
    .MATRIX_SIZE_PARA(N),
    .BW_TENSOR_SCALAR(8)
  ) dut (
    .clk            (clk),
    .rstnn          (rstnn),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .store_valid    (store_valid),
    .store_ready    (store_ready),
    .store_data     (store_data),
    .store_last     (store_last),
    .drain_request  (drain_request),
    .clear_request  (clear_request),
    .matrix_full    (matrix_full),
    .row_count      (row_count),
    .move_wenable   (move_wenable),
    .move_wdata_list(move_wdata_list),
    .move_renable   (move_renable),
    .move_rdata_list(move_rdata_list),
    .init           (init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream matrix register: writes append at the bottom, reads pop the top row
  logic [RW-1:0] mem [N];
  int            mcnt;
  always @(posedge clk) begin
    if (rstnn || init) begin
      mcnt <= 0;
    end else if (move_renable && move_wenable) begin
      for (int i = 0; i < N - 1; i++) mem[i] <= mem[i+1];
      if (mcnt > 0) mem[mcnt-1] <= move_wdata_list;
    end else if (move_renable) begin
      for (int i = 0; i < N - 1; i++) mem[i] <= mem[i+1];
      if (mcnt > 0) mcnt <= mcnt - 1;
    end else if (move_wenable) begin
      if (mcnt < N) begin
        mem[mcnt] <= move_wdata_list;
        mcnt      <= mcnt + 1;
      end
    end
  end
  assign move_rdata_list = mem[0];

  task automatic idle_inputs();
    load_valid    = 1'b0;
    load_data     = '0;
    store_ready   = 1'b0;
    drain_request = 1'b0;
    clear_request = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstnn = 1'b1;
    idle_inputs();
    load_valid = 1'b1;
    #1;
    n_checks++;
    if (load_ready !== 1'b0 || move_wenable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: load_ready=%b move_wenable=%b, expected 0 0",
               load_ready, move_wenable);
    end
    @(negedge clk);
    rstnn      = 1'b0;
    load_valid = 1'b0;
    #1;
    n_checks++;
    if (row_count !== 3'd0 || matrix_full !== 1'b0 || store_valid !== 1'b0 ||
        store_last !== 1'b0 || init !== 1'b0 || move_renable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d full=%b sv=%b sl=%b init=%b ren=%b, expected 0 0 0 0 0 0",
               row_count, matrix_full, store_valid, store_last, init, move_renable);
    end
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_load_state: load_ready=%b, expected 1", load_ready);
    end
  endtask

  // Load rows 0x11111111..0x44444444 back to back
  task automatic test_load();
    int pulses = 0;
    for (int i = 0; i < N; i++) begin
      logic [RW-1:0] row;
      row = 32'h1111_1111 * (i + 1);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = row;
      #1;
      n_checks++;
      if (row_count !== CW'(i) || load_ready !== 1'b1 || move_wdata_list !== row) begin
        n_fail++;
        $display("FAIL load_beat%0d: cnt=%0d rdy=%b wdata=%h, expected %0d 1 %h",
                 i, row_count, load_ready, move_wdata_list, i, row);
      end
      if (move_wenable === 1'b1) pulses++;
      exp_q.push_back(row);
    end
    @(negedge clk);
    load_data = 32'h5555_5555;
    #1;
    if (move_wenable === 1'b1) pulses++;
    n_checks++;
    if (pulses != N) begin
      n_fail++;
      $display("FAIL load_wenable_pulses: got %0d, expected %0d", pulses, N);
    end
    n_checks++;
    if (matrix_full !== 1'b1 || load_ready !== 1'b0 || row_count !== 3'd4) begin
      n_fail++;
      $display("FAIL load_full: full=%b rdy=%b cnt=%0d, expected 1 0 4",
               matrix_full, load_ready, row_count);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_drain();
    bit done = 1'b0;
    @(negedge clk);
    drain_request = 1'b1;
    #1;
    n_checks++;
    if (store_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_request_cycle: store_valid=%b, expected 0", store_valid);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      drain_request = 1'b0;
      store_ready   = (c % 2 == 0);
      #1;
      n_checks++;
      if (store_valid !== 1'b1 || matrix_full !== 1'b0 || row_count !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL drain_state: sv=%b full=%b cnt=%0d, expected 1 0 %0d",
                 store_valid, matrix_full, row_count, exp_q.size());
      end
      if (store_ready) begin
        logic [RW-1:0] e;
        logic          el;
        e  = exp_q.pop_front();
        el = (exp_q.size() == 0);
        n_checks++;
        if (store_data !== e || store_last !== el || move_renable !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_beat: data=%h last=%b ren=%b, expected %h %b 1",
                   store_data, store_last, move_renable, e, el);
        end
        done = el;
      end else begin
        n_checks++;
        if (move_renable !== 1'b0) begin
          n_fail++;
          $display("FAIL drain_stall: move_renable=%b, expected 0", move_renable);
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: store_last never seen, got 0 expected 1");
    end
    @(negedge clk);
    store_ready = 1'b0;
    #1;
    n_checks++;
    if (store_valid !== 1'b0 || row_count !== 3'd0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: sv=%b cnt=%0d rdy=%b, expected 0 0 1",
               store_valid, row_count, load_ready);
    end
  endtask

`ifdef DCA_ROW_STREAMER_OVERLAP_EN
  task automatic test_overlap();
    int both = 0;
    @(negedge clk);
    drain_request = 1'b1;
    @(negedge clk);
    drain_request = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [RW-1:0] nr;
      logic [RW-1:0] e;
      nr = 32'hAAAA_AAAA + 32'h1111_1111 * i;
      if (i != 0) @(negedge clk);
      store_ready = 1'b1;
      load_valid  = 1'b1;
      load_data   = nr;
      #1;
      e = exp_q.pop_front();
      if (move_wenable === 1'b1 && move_renable === 1'b1) both++;
      n_checks++;
      if (store_data !== e || store_last !== (i == N - 1) || load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL overlap_beat%0d: data=%h last=%b rdy=%b, expected %h %b 1",
                 i, store_data, store_last, load_ready, e, i == N - 1);
      end
      exp_q.push_back(nr);
    end
    @(negedge clk);
    store_ready = 1'b0;
    load_valid  = 1'b0;
    #1;
    n_checks++;
    if (both != N) begin
      n_fail++;
      $display("FAIL overlap_strobes: got %0d, expected %0d", both, N);
    end
    n_checks++;
    if (matrix_full !== 1'b1 || row_count !== 3'd4 || store_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_full: full=%b cnt=%0d sv=%b, expected 1 4 0",
               matrix_full, row_count, store_valid);
    end
    @(negedge clk);
    clear_request = 1'b1;
    #1;
    n_checks++;
    if (init !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_clear_init: got %b, expected 1", init);
    end
    @(negedge clk);
    clear_request = 1'b0;
    exp_q.delete();
  endtask
`endif

  // Drain ignored in LOAD, then clear on the third load beat
  task automatic test_drain_ignored_and_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 32'h0101_0101 << i;
    end
    @(negedge clk);
    load_valid    = 1'b0;
    drain_request = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      drain_request = 1'b0;
      n_checks++;
      if (store_valid !== 1'b0 || row_count !== 3'd2 || load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_ignored: sv=%b cnt=%0d rdy=%b, expected 0 2 1",
                 store_valid, row_count, load_ready);
      end
    end
    @(negedge clk);
    load_valid    = 1'b1;
    load_data     = 32'h3333_3333;
    clear_request = 1'b1;
    #1;
    n_checks++;
    if (init !== 1'b1 || move_wenable !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cycle: init=%b wen=%b rdy=%b, expected 1 0 0",
               init, move_wenable, load_ready);
    end
    @(negedge clk);
    load_valid    = 1'b0;
    clear_request = 1'b0;
    #1;
    n_checks++;
    if (init !== 1'b0 || row_count !== 3'd0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_after: init=%b cnt=%0d rdy=%b, expected 0 0 1",
               init, row_count, load_ready);
    end
  endtask

  task automatic test_reset_mid_store();
    test_load();
    @(negedge clk);
    drain_request = 1'b1;
    @(negedge clk);
    drain_request = 1'b0;
    store_ready   = 1'b1;
    load_valid    = 1'b1;
    load_data     = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    n_checks++;
    if (row_count !== 3'd3 || store_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midstore_progress: cnt=%0d sv=%b, expected 3 1", row_count, store_valid);
    end
    @(negedge clk);
    rstnn = 1'b1;
    #1;
    n_checks++;
    if (store_valid !== 1'b0 || move_renable !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midstore_reset_cycle: sv=%b ren=%b rdy=%b, expected 0 0 0",
               store_valid, move_renable, load_ready);
    end
    @(negedge clk);
    rstnn = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (row_count !== 3'd0 || matrix_full !== 1'b0 || store_valid !== 1'b0 ||
        store_last !== 1'b0 || load_ready !== 1'b1 || init !== 1'b0) begin
      n_fail++;
      $display("FAIL midstore_after: cnt=%0d full=%b sv=%b sl=%b rdy=%b init=%b, expected 0 0 0 0 1 0",
               row_count, matrix_full, store_valid, store_last, load_ready, init);
    end
    exp_q.delete();
  endtask

  initial begin
    rstnn = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
`ifdef DCA_ROW_STREAMER_OVERLAP_EN
    test_overlap();
`else
    test_drain();
`endif
    test_drain_ignored_and_clear();
    test_reset_mid_store();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
